sensor_clk_gen: RTL
===================

Name: sensor_clk_gen

Overview:
- Synthesizable, parametrised successor to the behavioural 1 GHz toggle generator used in the colour-sensor testbench.
- Divides the system clock into a 50%-duty square wave, clk_out, selected from four frequency-scaling modes, mirroring the sensor's S0/S1 output-scaling settings.
- Drives the sensor-model output and the frequency-measurement counters.
- Mode changes and stop requests take effect only at period boundaries, so clk_out never produces a runt pulse.

Parameters:
- CNT_W, 16, width of the half-period down-counter.
- HALF0, 5000, half-period of mode 0 in clk cycles (5 us at 1 GHz).
- HALF1, 1250, half-period of mode 1 (1.25 us).
- HALF2, 500, half-period of mode 2 (0.5 us).
- HALF3, 147, half-period of mode 3 (~147 ns).
- FRAC0..FRAC3, 0/0/0/15, fractional half-period extension in 1/256 cycle units; used only with CLK_GEN_FRAC_EN.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, run request; level-sensitive.
- mode, input, 2, requested scaling mode.
- clk_out, output, 1, generated clock (registered).
- rise_tick, output, 1, one-cycle pulse in the cycle clk_out goes 0->1.
- fall_tick, output, 1, one-cycle pulse in the cycle clk_out goes 1->0.
- mode_active, output, 2, mode currently generating.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, clk_out=0, rise_tick=0, fall_tick=0, busy=0, mode_active=0, counter=0, fractional accumulator=0.
- Per-mode half-period H[m]:
  - Parameter value; a value of 0 is clamped to 1 at elaboration.
  - Each value must fit in CNT_W bits; elaboration error otherwise.
- FSM states: IDLE, HIGH, LOW.
- IDLE, on an edge with en=1:
  - mode_active<=mode, clk_out<=1, rise_tick<=1, cnt<=H[mode]-1, state->HIGH.
  - Latency en->clk_out rising is 1 clk.
- HIGH:
  - cnt!=0: decrement cnt.
  - cnt==0: clk_out<=0, fall_tick<=1, cnt<=H[mode_active]-1, state->LOW.
- LOW, cnt!=0: decrement cnt.
- LOW, cnt==0 and en=1:
  - Sample mode: mode_active<=mode, clk_out<=1, rise_tick<=1, cnt<=H[mode]-1, state->HIGH.
  - A new mode therefore starts on a fresh period.
- LOW, cnt==0 and en=0: state->IDLE; clk_out stays 0.
- Steady state:
  - clk_out is high exactly H cycles and low exactly H cycles; period 2*H; duty exactly 50%.
  - rise_tick and fall_tick are never high in the same cycle.
- en deasserted mid-period: the current period completes (HIGH and LOW phases); no truncation.
- en re-asserted before the LOW phase ends: seamless continuation, no IDLE cycle.
- mode changes mid-period: ignored until the next LOW->HIGH boundary. Only the value present on that edge matters; intermediate values are discarded.
- busy=1 from the edge entering HIGH through the last LOW cycle; 0 in IDLE.
- Reset asserted mid-operation: immediate return to reset values, regardless of phase.

Optional Feature:
- Macro: CLK_GEN_FRAC_EN.
- Defined:
  - An 8-bit accumulator per instance; at every phase load, acc<=acc+FRAC[m].
  - On carry-out, that phase lasts H+1 cycles instead of H.
  - Average half-period is H+FRAC/256; e.g. mode 3 averages 147.059 cycles.
  - Accumulator clears on reset and whenever mode_active changes value.
  - Duty may differ by one cycle between adjacent phases.
- Not defined: FRAC parameters are ignored, no accumulator is built, and every phase is exactly H cycles.

Test Plan:
- Bench parameters: HALF0=4, HALF1=2, HALF2=1, HALF3=3.
- Reset: rst_n=0 mid-HIGH -> clk_out, busy, ticks and mode_active all 0 immediately (asynchronously); after release with en=0, clk_out stays 0 for 20 cycles.
- Start: en=1, mode=0 at edge N -> clk_out=1 from edge N, 4 high / 4 low cycles repeating; rise_tick at N, N+8, N+16; fall_tick at N+4, N+12.
- Mode switch: mode 0->2 driven at cycle 2 of HIGH -> current 8-cycle period completes unchanged; next period is 1 high / 1 low; mode_active updates at that rising edge.
- Stop: en=0 at cycle 1 of HIGH in mode 1 -> 2 high / 2 low cycles complete, then IDLE and busy=0. Re-assert en on the last LOW cycle (separate run) -> no gap, next rise on schedule.
- Mode 2 boundary: H=1 -> clk_out toggles every clk; ticks alternate every cycle; mode change accepted every 2 cycles.
- With CLK_GEN_FRAC_EN, FRAC3=128, mode 3: phase lengths 3,4,3,4,... Switch to mode 0 -> accumulator clears, then phases are 4,4,4,...

Source files
------------

// File: rtl/sensor_clk_gen.sv
// sensor_clk_gen: divides clk into a 50%-duty square wave for the colour-sensor
// model, with four frequency-scaling modes that mirror the sensor's S0/S1
// output-scaling settings. Mode changes and stop requests are applied only at
// period boundaries, so clk_out never produces a runt pulse.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          run request (level)
//   mode[1:0]   requested scaling mode, sampled at each LOW->HIGH boundary
//   clk_out     generated clock (registered)
//   rise_tick   one-cycle pulse in the cycle clk_out goes 0->1
//   fall_tick   one-cycle pulse in the cycle clk_out goes 1->0
//   mode_active mode currently generating
//   busy        high whenever the generator is not idle
//
// Optional feature: define CLK_GEN_FRAC_EN to build an 8-bit fractional
// accumulator. A phase whose load carries out of the accumulator is one cycle
// longer, giving an average half-period of HALFm + FRACm/256.

module sensor_clk_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned HALF0 = 5000,
  parameter int unsigned HALF1 = 1250,
  parameter int unsigned HALF2 = 500,
  parameter int unsigned HALF3 = 147,
  parameter int unsigned FRAC0 = 0,
  parameter int unsigned FRAC1 = 0,
  parameter int unsigned FRAC2 = 0,
  parameter int unsigned FRAC3 = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  output logic       clk_out,
  output logic       rise_tick,
  output logic       fall_tick,
  output logic [1:0] mode_active,
  output logic       busy
);

  // Half-periods with zero clamped to one
  localparam int unsigned H0 = (HALF0 == 0) ? 1 : HALF0;
  localparam int unsigned H1 = (HALF1 == 0) ? 1 : HALF1;
  localparam int unsigned H2 = (HALF2 == 0) ? 1 : HALF2;
  localparam int unsigned H3 = (HALF3 == 0) ? 1 : HALF3;

  // Elaboration-time range checks
  if (((H0 >> CNT_W) != 0) || ((H1 >> CNT_W) != 0) ||
      ((H2 >> CNT_W) != 0) || ((H3 >> CNT_W) != 0)) begin : g_half_range_err
    $error("sensor_clk_gen: a HALFn value does not fit in CNT_W bits");
  end
  if ((FRAC0 > 255) || (FRAC1 > 255) || (FRAC2 > 255) || (FRAC3 > 255)) begin : g_frac_range_err
    $error("sensor_clk_gen: a FRACn value does not fit in 8 bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Counter reload value (half-period minus one) for a mode
  function automatic logic [CNT_W-1:0] half_m1(input logic [1:0] m);
    case (m)
      2'd0:    half_m1 = CNT_W'(H0 - 1);
      2'd1:    half_m1 = CNT_W'(H1 - 1);
      2'd2:    half_m1 = CNT_W'(H2 - 1);
      default: half_m1 = CNT_W'(H3 - 1);
    endcase
  endfunction

`ifdef CLK_GEN_FRAC_EN
  function automatic logic [7:0] frac_of(input logic [1:0] m);
    case (m)
      2'd0:    frac_of = 8'(FRAC0);
      2'd1:    frac_of = 8'(FRAC1);
      2'd2:    frac_of = 8'(FRAC2);
      default: frac_of = 8'(FRAC3);
    endcase
  endfunction

  logic [7:0] acc_q, acc_d, acc_base;
  logic       carry;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_d, rise_d, fall_d;
  logic [1:0]       mode_d, load_mode;
  logic             load;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clk_out     <= 1'b0;
      rise_tick   <= 1'b0;
      fall_tick   <= 1'b0;
      mode_active <= 2'd0;
      busy        <= 1'b0;
`ifdef CLK_GEN_FRAC_EN
      acc_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_out     <= clk_d;
      rise_tick   <= rise_d;
      fall_tick   <= fall_d;
      mode_active <= mode_d;
      busy        <= (state_d != IDLE);
`ifdef CLK_GEN_FRAC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  // Next-state, counter and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_d     = clk_out;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    mode_d    = mode_active;
    load_mode = mode_active;
    load      = 1'b0;
`ifdef CLK_GEN_FRAC_EN
    acc_d     = acc_q;
    acc_base  = acc_q;
    carry     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (en) begin
          load      = 1'b1;
          load_mode = mode;
          mode_d    = mode;
          clk_d     = 1'b1;
          rise_d    = 1'b1;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          load    = 1'b1;
          clk_d   = 1'b0;
          fall_d  = 1'b1;
          state_d = LOW;
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (en) begin
          // Period boundary: the only place a new mode is accepted
          load      = 1'b1;
          load_mode = mode;
          mode_d    = mode;
          clk_d     = 1'b1;
          rise_d    = 1'b1;
          state_d   = HIGH;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Phase load; a carry stretches this phase by one cycle
    if (load) begin
`ifdef CLK_GEN_FRAC_EN
      acc_base       = (load_mode != mode_active) ? 8'd0 : acc_q;
      {carry, acc_d} = 9'(acc_base) + 9'(frac_of(load_mode));
      cnt_d          = half_m1(load_mode) + CNT_W'(carry);
`else
      cnt_d = half_m1(load_mode);
`endif
    end
  end

endmodule
